// File: rtl/bch_pkg.sv
// Shared constants, state encoding and GF(16) helpers for the BCH(15,7) decoder.
// Field is GF(16) built on x^4+x+1 with alpha = x.
package bch_pkg;

   localparam int         N          = 15;
   localparam logic [3:0] GF_POLY    = 4'b0011;
   localparam logic [3:0] ALPHA      = 4'b0010;
   localparam logic [3:0] ALPHA3     = 4'b1000;
   localparam logic [3:0] ALPHA_INV  = 4'b1001;  // alpha^14
   localparam logic [3:0] ALPHA_INV2 = 4'b1101;  // alpha^13

   typedef enum logic [2:0] {
      IDLE,
      SYND,
      CHECK,
      BM,
      LATCH,
      CHIEN,
      DONE
   } bch_ctrl_state_t;

   // Squaring is linear over GF(2): x^4 -> x+1, x^6 -> x^3+x^2.
   function automatic logic [3:0] gf_sq(input logic [3:0] a);
      return {a[3], a[1] ^ a[3], a[2], a[0] ^ a[2]};
   endfunction

endpackage

// File: rtl/bch_bm_block.sv
// One-step error-locator solver for t=2: lambda1 = S1, lambda2 = S3/S1 + S2.
// Outputs are registered and held at zero while srst is high.
import bch_pkg::*;

module bch_bm_block (
   input  logic       clk,
   input  logic       srst,
   input  logic [3:0] s1,
   input  logic [3:0] s2,
   input  logic [3:0] s3,
   output logic [3:0] lambda1,
   output logic [3:0] lambda2
);

   logic [3:0] s1_inv;
   logic [3:0] quot;

   always_comb begin
      s1_inv = 4'h0;
      case (s1)
         4'h1: s1_inv = 4'h1;
         4'h2: s1_inv = 4'h9;
         4'h3: s1_inv = 4'hE;
         4'h4: s1_inv = 4'hD;
         4'h5: s1_inv = 4'hB;
         4'h6: s1_inv = 4'h7;
         4'h7: s1_inv = 4'h6;
         4'h8: s1_inv = 4'hF;
         4'h9: s1_inv = 4'h2;
         4'hA: s1_inv = 4'hC;
         4'hB: s1_inv = 4'h5;
         4'hC: s1_inv = 4'hA;
         4'hD: s1_inv = 4'h4;
         4'hE: s1_inv = 4'h3;
         4'hF: s1_inv = 4'h8;
         default: s1_inv = 4'h0;
      endcase
   end

   gf_multiplier u_div (.a(s3), .b(s1_inv), .p(quot));

   always_ff @(posedge clk) begin
      if (srst) begin
         lambda1 <= 4'h0;
         lambda2 <= 4'h0;
      end else begin
         lambda1 <= s1;
         lambda2 <= quot ^ s2;
      end
   end

endmodule

// File: rtl/bch_decode_ctrl_chien_step.sv
// One Chien-search position: root test on 1+t1+t2 and advance of both terms.
import bch_pkg::*;

module bch_chien_step (
   input  logic [3:0] t1,
   input  logic [3:0] t2,
   output logic       root,
   output logic [3:0] t1_next,
   output logic [3:0] t2_next
);

   assign root = ((4'b0001 ^ t1 ^ t2) == 4'b0000);

   gf_multiplier u_mul_t1 (.a(t1), .b(ALPHA_INV),  .p(t1_next));
   gf_multiplier u_mul_t2 (.a(t2), .b(ALPHA_INV2), .p(t2_next));

endmodule

// File: rtl/gf_multiplier.sv
// Combinational GF(16) multiplier, shift-and-add with reduction by x^4+x+1.
import bch_pkg::*;

module gf_multiplier (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] p
);

   logic [3:0] acc;
   logic [3:0] sh;

   always_comb begin
      acc = 4'b0000;
      sh  = a;
      for (int k = 0; k < 4; k++) begin
         if (b[k]) acc = acc ^ sh;
         sh = {sh[2:0], 1'b0} ^ (sh[3] ? GF_POLY : 4'b0000);
      end
      p = acc;
   end

endmodule

// File: rtl/bch_decode_ctrl.sv
// BCH(15,7) t=2 decode sequencer: serial syndromes, one BM step, serial Chien search.
// Owns the clear/timing of the external bch_bm_block.
import bch_pkg::*;

module bch_decode_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic [1:0]   out_nerr,
   output logic         out_fail,
   output logic [3:0]   bm_s1,
   output logic [3:0]   bm_s2,
   output logic [3:0]   bm_s3,
   output logic         bm_clr,
   input  logic [3:0]   bm_lambda1,
   input  logic [3:0]   bm_lambda2
);

   bch_ctrl_state_t state_reg, state_next;

   logic [N-1:0] raw_reg, work_reg, out_data_reg, work_upd;
   logic [3:0]   s1_reg, s3_reg, s1_mul, s3_mul;
   logic [3:0]   lam2_reg, t1_reg, t2_reg, t1_step, t2_step;
   logic [3:0]   cnt_reg, bit_idx;
   logic [1:0]   roots_reg, roots_upd, out_nerr_reg, deg;
   logic         out_fail_reg, root, last_cnt, chien_ok;

   gf_multiplier u_mul_s1 (.a(s1_reg), .b(ALPHA),  .p(s1_mul));
   gf_multiplier u_mul_s3 (.a(s3_reg), .b(ALPHA3), .p(s3_mul));

   bch_chien_step u_chien (
      .t1      (t1_reg),
      .t2      (t2_reg),
      .root    (root),
      .t1_next (t1_step),
      .t2_next (t2_step)
   );

   assign last_cnt = (cnt_reg == 4'(N - 1));
   assign bit_idx  = 4'(N - 1) - cnt_reg;
   assign deg      = (lam2_reg != 4'h0) ? 2'd2 : 2'd1;
   assign chien_ok = (roots_upd == deg);

   // Word and root count as they stand after the current Chien position.
   always_comb begin
      work_upd  = work_reg;
      roots_upd = roots_reg;
      if (root) begin
         work_upd[cnt_reg] = ~work_reg[cnt_reg];
         if (roots_reg != 2'd3) roots_upd = roots_reg + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      bm_clr     = 1'b1;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = SYND;
         end
         SYND:  if (last_cnt) state_next = CHECK;
         CHECK: state_next = (s1_reg == 4'h0) ? DONE : BM;
         BM: begin
            bm_clr     = 1'b0;
            state_next = LATCH;
         end
         LATCH: state_next = CHIEN;
         CHIEN: if (last_cnt) state_next = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         raw_reg      <= '0;
         work_reg     <= '0;
         out_data_reg <= '0;
         s1_reg       <= 4'h0;
         s3_reg       <= 4'h0;
         lam2_reg     <= 4'h0;
         t1_reg       <= 4'h0;
         t2_reg       <= 4'h0;
         cnt_reg      <= 4'h0;
         roots_reg    <= 2'd0;
         out_nerr_reg <= 2'd0;
         out_fail_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: if (in_valid) begin
               raw_reg <= in_data;
               s1_reg  <= 4'h0;
               s3_reg  <= 4'h0;
               cnt_reg <= 4'h0;
            end
            // Horner form, highest-order coefficient first.
            SYND: begin
               s1_reg  <= s1_mul ^ {3'b000, raw_reg[bit_idx]};
               s3_reg  <= s3_mul ^ {3'b000, raw_reg[bit_idx]};
               cnt_reg <= cnt_reg + 4'd1;
            end
            CHECK: if (s1_reg == 4'h0) begin
               out_data_reg <= raw_reg;
               out_nerr_reg <= 2'd0;
               out_fail_reg <= (s3_reg != 4'h0);
            end
            LATCH: begin
               lam2_reg  <= bm_lambda2;
               t1_reg    <= bm_lambda1;
               t2_reg    <= bm_lambda2;
               cnt_reg   <= 4'h0;
               roots_reg <= 2'd0;
               work_reg  <= raw_reg;
            end
            CHIEN: begin
               t1_reg    <= t1_step;
               t2_reg    <= t2_step;
               work_reg  <= work_upd;
               roots_reg <= roots_upd;
               cnt_reg   <= cnt_reg + 4'd1;
               if (last_cnt) begin
                  out_data_reg <= chien_ok ? work_upd : raw_reg;
                  out_nerr_reg <= chien_ok ? roots_upd : 2'd0;
                  out_fail_reg <= !chien_ok;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_data = out_data_reg;
   assign out_nerr = out_nerr_reg;
   assign out_fail = out_fail_reg;
   assign bm_s1    = s1_reg;
   assign bm_s2    = gf_sq(s1_reg);
   assign bm_s3    = s3_reg;

endmodule

// File: tb/tb_bch_decode_ctrl.sv
// Bench for bch_decode_ctrl + bch_bm_block; reference is a brute-force
// bounded-distance decoder over all weight-1 and weight-2 error patterns.
module tb_bch_decode_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [14:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [14:0] out_data;
   logic [1:0]  out_nerr;
   logic        out_fail;
   logic [3:0]  bm_s1, bm_s2, bm_s3;
   logic        bm_clr;
   logic [3:0]  bm_lambda1, bm_lambda2;

   int checks = 0;
   int errors = 0;
   logic [3:0] pow_tab [0:14];

   always #5 clk = ~clk;

   bch_decode_ctrl dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_nerr(out_nerr), .out_fail(out_fail),
      .bm_s1(bm_s1), .bm_s2(bm_s2), .bm_s3(bm_s3), .bm_clr(bm_clr),
      .bm_lambda1(bm_lambda1), .bm_lambda2(bm_lambda2)
   );

   bch_bm_block bm (
      .clk(clk), .srst(bm_clr),
      .s1(bm_s1), .s2(bm_s2), .s3(bm_s3),
      .lambda1(bm_lambda1), .lambda2(bm_lambda2)
   );

   function automatic logic [3:0] syn(input logic [14:0] w, input int m);
      logic [3:0] s = 4'h0;
      for (int i = 0; i < 15; i++) if (w[i]) s ^= pow_tab[(m * i) % 15];
      return s;
   endfunction

   task automatic ref_decode(input logic [14:0] w, output logic [14:0] d,
                             output logic [1:0] ne, output logic fl, output logic fast);
      logic [3:0] s1, s3;
      logic found;
      s1 = syn(w, 1);
      s3 = syn(w, 3);
      d = w; ne = 2'd0; fl = 1'b0; fast = (s1 == 4'h0); found = 1'b0;
      if (fast) begin
         fl = (s3 != 4'h0);
         return;
      end
      for (int i = 0; i < 15; i++)
         if (!found && pow_tab[i] == s1 && pow_tab[(3 * i) % 15] == s3) begin
            d = w ^ (15'd1 << i); ne = 2'd1; found = 1'b1;
         end
      for (int i = 0; i < 15; i++)
         for (int j = i + 1; j < 15; j++)
            if (!found && (pow_tab[i] ^ pow_tab[j]) == s1 &&
                (pow_tab[(3 * i) % 15] ^ pow_tab[(3 * j) % 15]) == s3) begin
               d = w ^ (15'd1 << i) ^ (15'd1 << j); ne = 2'd2; found = 1'b1;
            end
      if (!found) fl = 1'b1;
   endtask

   function automatic logic [14:0] encode(input logic [6:0] m);
      logic [14:0] c = '0;
      logic [14:0] g = 15'h01D1;
      for (int i = 0; i < 7; i++) if (m[i]) c ^= (g << i);
      return c;
   endfunction

   task automatic start_word(input logic [14:0] w);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Leaves the bench #1 after the edge that starts the first out_valid cycle.
   task automatic wait_done(output int lat, output int clr_lows, output int rdy_highs);
      lat = 1; clr_lows = 0; rdy_highs = 0;
      while (!out_valid && lat < 100) begin
         if (!bm_clr) clr_lows++;
         if (in_ready) rdy_highs++;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic finish_word();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || bm_clr !== 1'b1) begin
         errors++;
         $display("FAIL reset_ctrl: in_ready=%b out_valid=%b bm_clr=%b required 1 0 1", in_ready, out_valid, bm_clr);
      end
      checks++;
      if (out_data !== 15'h0 || out_nerr !== 2'd0 || out_fail !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: data=%h nerr=%0d fail=%b required 0000 0 0", out_data, out_nerr, out_fail);
      end
      checks++;
      if (bm_s1 !== 4'h0 || bm_s2 !== 4'h0 || bm_s3 !== 4'h0) begin
         errors++;
         $display("FAIL reset_synd: s1=%h s2=%h s3=%h required 0 0 0", bm_s1, bm_s2, bm_s3);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_directed();
      logic [14:0] words [5] = '{15'h0000, 15'h01D1, 15'h01D0, 15'h4001, 15'h0421};
      logic [14:0] exp_d [5] = '{15'h0000, 15'h01D1, 15'h01D1, 15'h0000, 15'h0421};
      logic [1:0]  exp_n [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
      logic        exp_f [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      int          exp_l [5] = '{17, 17, 34, 34, 17};
      int lat, clr_lows, rdy;
      for (int k = 0; k < 5; k++) begin
         start_word(words[k]);
         wait_done(lat, clr_lows, rdy);
         $display("directed word=%h data=%h nerr=%0d fail=%b lat=%0d", words[k], out_data, out_nerr, out_fail, lat);
         checks++;
         if (out_data !== exp_d[k] || out_nerr !== exp_n[k] || out_fail !== exp_f[k]) begin
            errors++;
            $display("FAIL directed_result word=%h: got %h/%0d/%b required %h/%0d/%b",
                     words[k], out_data, out_nerr, out_fail, exp_d[k], exp_n[k], exp_f[k]);
         end
         checks++;
         if (lat != exp_l[k]) begin
            errors++;
            $display("FAIL directed_latency word=%h: got %0d required %0d", words[k], lat, exp_l[k]);
         end
         checks++;
         if (clr_lows != ((exp_l[k] == 34) ? 1 : 0) || rdy != 0) begin
            errors++;
            $display("FAIL directed_ctrl word=%h: bm_clr low %0d cycles, in_ready high %0d cycles", words[k], clr_lows, rdy);
         end
         finish_word();
      end
   endtask

   task automatic test_random();
      logic [14:0] w, d;
      logic [1:0]  ne;
      logic        fl, fast;
      int lat, clr_lows, rdy, nerr_ins, p;
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 4) == 0) w = 15'($urandom);
         else begin
            w = encode(7'($urandom));
            nerr_ins = $urandom_range(0, 3);
            for (int e = 0; e < nerr_ins; e++) begin
               p = $urandom_range(0, 14);
               w[p] = ~w[p];
            end
         end
         ref_decode(w, d, ne, fl, fast);
         start_word(w);
         wait_done(lat, clr_lows, rdy);
         $display("random word=%h data=%h nerr=%0d fail=%b lat=%0d", w, out_data, out_nerr, out_fail, lat);
         checks++;
         if (out_data !== d || out_nerr !== ne || out_fail !== fl) begin
            errors++;
            $display("FAIL random_result word=%h: got %h/%0d/%b required %h/%0d/%b",
                     w, out_data, out_nerr, out_fail, d, ne, fl);
         end
         checks++;
         if (lat != (fast ? 17 : 34) || clr_lows != (fast ? 0 : 1)) begin
            errors++;
            $display("FAIL random_timing word=%h: lat %0d clr_lows %0d required %0d %0d",
                     w, lat, clr_lows, fast ? 17 : 34, fast ? 0 : 1);
         end
         finish_word();
      end
   endtask

   task automatic test_back_to_back();
      logic [14:0] w1, w2, w3, d, d0;
      logic [1:0]  ne, ne0;
      logic        fl, fl0, fast;
      int lat, clr_lows, rdy;
      w1 = 15'h01D1 ^ 15'h0008 ^ 15'h0200;
      start_word(w1);
      wait_done(lat, clr_lows, rdy);
      d0 = out_data; ne0 = out_nerr; fl0 = out_fail;
      checks++;
      if (d0 !== 15'h01D1 || ne0 !== 2'd2 || fl0 !== 1'b0) begin
         errors++;
         $display("FAIL bp_result: got %h/%0d/%b required 01d1/2/0", d0, ne0, fl0);
      end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== d0 ||
             out_nerr !== ne0 || out_fail !== fl0) begin
            errors++;
            $display("FAIL bp_hold cycle %0d: valid=%b ready=%b data=%h nerr=%0d fail=%b required 1 0 %h %0d %b",
                     c, out_valid, in_ready, out_data, out_nerr, out_fail, d0, ne0, fl0);
         end
      end
      $display("backpressure word=%h held data=%h for 10 cycles", w1, d0);
      // Handshake and a new offer in the same cycle: the offer must wait for IDLE.
      w2 = encode(7'h5A) ^ 15'h2000;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = w2;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept: in_ready=%b required 0", in_ready);
      end
      ref_decode(w2, d, ne, fl, fast);
      wait_done(lat, clr_lows, rdy);
      $display("back_to_back word=%h data=%h nerr=%0d fail=%b lat=%0d", w2, out_data, out_nerr, out_fail, lat);
      checks++;
      if (out_data !== d || out_nerr !== ne || out_fail !== fl || lat != (fast ? 17 : 34)) begin
         errors++;
         $display("FAIL b2b_result: got %h/%0d/%b lat %0d required %h/%0d/%b lat %0d",
                  out_data, out_nerr, out_fail, lat, d, ne, fl, fast ? 17 : 34);
      end
      finish_word();
      // Reset asserted at cycle 25 of a full-path word.
      w3 = encode(7'h33) ^ 15'h0101;
      start_word(w3);
      repeat (24) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || bm_clr !== 1'b1 || out_data !== 15'h0 ||
          out_nerr !== 2'd0 || out_fail !== 1'b0 || bm_s1 !== 4'h0 || bm_s3 !== 4'h0) begin
         errors++;
         $display("FAIL mid_reset: ready=%b valid=%b clr=%b data=%h nerr=%0d fail=%b s1=%h s3=%h required 1 0 1 0000 0 0 0 0",
                  in_ready, out_valid, bm_clr, out_data, out_nerr, out_fail, bm_s1, bm_s3);
      end
      $display("mid_reset word=%h discarded", w3);
      @(negedge clk);
      rst = 1'b1;
      w2 = encode(7'h11) ^ 15'h0840;
      ref_decode(w2, d, ne, fl, fast);
      start_word(w2);
      wait_done(lat, clr_lows, rdy);
      $display("after_reset word=%h data=%h nerr=%0d fail=%b lat=%0d", w2, out_data, out_nerr, out_fail, lat);
      checks++;
      if (out_data !== d || out_nerr !== ne || out_fail !== fl || lat != (fast ? 17 : 34)) begin
         errors++;
         $display("FAIL after_reset: got %h/%0d/%b lat %0d required %h/%0d/%b lat %0d",
                  out_data, out_nerr, out_fail, lat, d, ne, fl, fast ? 17 : 34);
      end
      finish_word();
   endtask

   initial begin
      logic [4:0] v;
      v = 5'd1;
      for (int k = 0; k < 15; k++) begin
         pow_tab[k] = v[3:0];
         v = {v[3:0], 1'b0};
         if (v[4]) v = v ^ 5'b10011;
      end
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
